// File: rtl/mem_pkg.sv
// Shared definitions for the load/store front end.
//   - size encodings for byte / half / word / reserved requests
//   - FSM state enum for load_store_unit
//   - misaligned(): flags a request that cannot be issued to memory
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        RESP = 3'd2,
        WR   = 3'd3,
        ERR  = 3'd4
    } lsu_state_t;

    // True when the byte offset is illegal for the access size, or the size
    // itself is the reserved encoding.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = off[0];
            SZ_WORD: bad = (off != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic for the load/store unit.
//   size        : access size (mem_pkg SZ_* encoding)
//   is_unsigned : loads only, 1 = zero-extend, 0 = sign-extend
//   off         : byte offset within the word (little-endian, lane 0 = bits 7:0)
//   rdata       : word read from memory
//   wdata       : right-aligned store data
//   load_data   : selected lane, extended to 32 bits
//   merge_data  : rdata with the addressed lane replaced by wdata (word size: wdata)
module lsu_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [1:0]  off,
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    logic [31:0] shifted;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        shifted = rdata >> {off, 3'b000};
        byte_v  = shifted[7:0];
        half_v  = off[1] ? rdata[31:16] : rdata[15:0];

        case (size)
            SZ_BYTE: load_data = {{24{~is_unsigned & byte_v[7]}}, byte_v};
            SZ_HALF: load_data = {{16{~is_unsigned & half_v[15]}}, half_v};
            default: load_data = rdata;
        endcase
    end

    always_comb begin
        merge_data = rdata;
        case (size)
            SZ_BYTE: merge_data[{off, 3'b000} +: 8]       = wdata[7:0];
            SZ_HALF: merge_data[{off[1], 4'b0000} +: 16]  = wdata[15:0];
            SZ_WORD: merge_data                            = wdata;
            default: merge_data                            = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Byte-addressed load/store front end for a word-addressed memory with a
// one-cycle synchronous read and no byte enables.
//   clk, rst      : clock (rising edge), asynchronous active-high reset
//   req_*         : request; accepted on an edge where req_valid && req_ready.
//                   req_ready is high only in IDLE; all fields are captured
//                   on accept and ignored afterwards.
//   resp_valid    : one-cycle completion pulse; resp_err / resp_rdata
//                   qualified by it (resp_rdata reads 0 outside RESP).
//   mem_*         : memory port; mem_rdata valid the cycle after mem_addr.
// Sequences: load IDLE-RD-RESP, word store IDLE-WR, sub-word store
// IDLE-RD-WR (read-modify-write), bad alignment/size IDLE-ERR.
module load_store_unit
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [31:0]           req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic                  resp_err,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    lsu_state_t state, state_n;

    logic                  we_q;
    logic [1:0]            size_q;
    logic                  uns_q;
    logic [1:0]            off_q;
    logic [ADDR_WIDTH-1:0] waddr_q;
    logic [DATA_WIDTH-1:0] wdata_q;

    logic                  accept;
    logic                  bad_req;
    logic [DATA_WIDTH-1:0] load_data;
    logic [DATA_WIDTH-1:0] merge_data;

    // High address bits are intentionally dropped: addresses wrap.
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr[31:ADDR_WIDTH+2];

    assign accept  = req_valid && (state == IDLE);
    assign bad_req = misaligned(req_size, req_addr[1:0]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q    <= 1'b0;
            size_q  <= SZ_BYTE;
            uns_q   <= 1'b0;
            off_q   <= 2'b00;
            waddr_q <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            we_q    <= req_we;
            size_q  <= req_size;
            uns_q   <= req_unsigned;
            off_q   <= req_addr[1:0];
            wdata_q <= req_wdata;
            // Rejected requests never touch memory, so leave the address alone.
            if (!bad_req) begin
                waddr_q <= req_addr[ADDR_WIDTH+1:2];
            end
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (bad_req) begin
                        state_n = ERR;
                    end else if (req_we && (req_size == SZ_WORD)) begin
                        state_n = WR;
                    end else begin
                        state_n = RD;
                    end
                end
            end
            RD:      state_n = we_q ? WR : RESP;
            RESP:    state_n = IDLE;
            WR:      state_n = IDLE;
            ERR:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    lsu_lane_align u_align (
        .size        (size_q),
        .is_unsigned (uns_q),
        .off         (off_q),
        .rdata       (mem_rdata),
        .wdata       (wdata_q),
        .load_data   (load_data),
        .merge_data  (merge_data)
    );

    // Outputs are decoded from state so reset clears them asynchronously;
    // in particular mem_we cannot survive a reset in mid-RMW.
    always_comb begin
        req_ready  = (state == IDLE);
        resp_valid = (state == RESP) || (state == WR) || (state == ERR);
        resp_err   = (state == ERR);
        resp_rdata = (state == RESP) ? load_data : '0;
        mem_we     = (state == WR);
        mem_addr   = waddr_q;
        mem_wdata  = (state == WR) ? merge_data : '0;
    end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    localparam int AW = 11;
    localparam int EW = 37;  // {lat[3:0], err, rdata[31:0]}

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic        mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;

    load_store_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_err     (resp_err),
        .resp_rdata   (resp_rdata),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    // ---------------- clock / reset / memory model ----------------
    always #5 clk = ~clk;

    logic [31:0] mem [0:(1<<AW)-1];
    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    end
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int we_cnt = 0;
    always @(posedge mem_we) we_cnt = we_cnt + 1;

    // ---------------- scoreboard ----------------
    logic [EW-1:0] exp_q[$];
    int tests = 0;
    int fails = 0;
    int acc_cyc = 0;

    always @(negedge clk) begin
        logic [EW-1:0] e;
        logic [EW-1:0] act;
        int lat;
        if (!rst) begin
            if (resp_valid) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_resp: err=%0b rdata=%08h, no response expected", resp_err, resp_rdata);
                end else begin
                    e = exp_q.pop_front();
                    lat = cyc - acc_cyc;
                    act = {lat[3:0], resp_err, resp_rdata};
                    if (e[36:33] == 4'd0) act[36:33] = 4'd0;
                    if (act !== e) begin
                        fails++;
                        $display("FAIL resp: got lat=%0d err=%0b rdata=%08h, want lat=%0d err=%0b rdata=%08h",
                                 act[36:33], act[32], act[31:0], e[36:33], e[32], e[31:0]);
                    end
                end
            end else begin
                tests++;
                if (resp_rdata !== 32'h0 || resp_err !== 1'b0) begin
                    fails++;
                    $display("FAIL idle_outputs: rdata=%08h err=%0b, want 0/0 without resp_valid", resp_rdata, resp_err);
                end
            end
        end
    end

    // ---------------- vectors ----------------
    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rdata;
        int          lat;
    } vec_t;

    vec_t tbl[$];

    task automatic add_vec(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic err, input logic [31:0] rdata, input int lat);
        vec_t v;
        v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
        v.err = err; v.rdata = rdata; v.lat = lat;
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h, want %0h", name, got, want);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) check("ready_timeout", 64'(req_ready), 64'd1);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 10) begin
            @(negedge clk); #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            check("resp_timeout", 64'(exp_q.size()), 64'd0);
            exp_q.delete();
        end
    endtask

    task automatic do_req(input vec_t v);
        logic [3:0] l;
        wait_ready();
        req_valid    = 1'b1;
        req_we       = v.we;
        req_size     = v.size;
        req_unsigned = v.uns;
        req_addr     = v.addr;
        req_wdata    = v.wdata;
        l = v.lat[3:0];
        exp_q.push_back({l, v.err, v.rdata});
        acc_cyc = cyc;
        @(posedge clk); #1;
        // Scramble inputs after accept: the unit must work from its own copy.
        req_valid    = 1'b0;
        req_we       = 1'($urandom_range(0, 1));
        req_size     = 2'($urandom_range(0, 3));
        req_unsigned = 1'($urandom_range(0, 1));
        req_addr     = $urandom;
        req_wdata    = $urandom;
        wait_drain();
    endtask

    localparam logic [1:0] B = 2'b00, H = 2'b01, W = 2'b10, R = 2'b11;

    initial begin
        int we0;
        vec_t v;

        // reset state
        #3;
        check("reset_outputs",
              64'({req_ready, resp_valid, resp_err, resp_rdata, mem_we, mem_addr, mem_wdata}),
              64'({1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 11'h0, 32'h0}));
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        //       we    size uns  addr          wdata         err   rdata         lat
        add_vec(1'b1, W, 1'b0, 32'h10,   32'hDEADBEEF, 1'b0, 32'h0,        1);
        add_vec(1'b0, W, 1'b0, 32'h10,   32'h0,        1'b0, 32'hDEADBEEF, 2);
        add_vec(1'b1, B, 1'b0, 32'h11,   32'h0000007F, 1'b0, 32'h0,        2);
        add_vec(1'b0, W, 1'b0, 32'h10,   32'h0,        1'b0, 32'hDEAD7FEF, 2);
        add_vec(1'b0, B, 1'b0, 32'h13,   32'h0,        1'b0, 32'hFFFFFFDE, 2);
        add_vec(1'b0, B, 1'b1, 32'h13,   32'h0,        1'b0, 32'h000000DE, 2);
        add_vec(1'b1, W, 1'b0, 32'h10,   32'h00000000, 1'b0, 32'h0,        1);
        add_vec(1'b1, H, 1'b0, 32'h12,   32'h00001234, 1'b0, 32'h0,        2);
        add_vec(1'b0, H, 1'b0, 32'h12,   32'h0,        1'b0, 32'h00001234, 2);
        add_vec(1'b0, H, 1'b0, 32'h10,   32'h0,        1'b0, 32'h00000000, 2);
        add_vec(1'b0, W, 1'b0, 32'h21,   32'h0,        1'b1, 32'h0,        1);
        add_vec(1'b1, H, 1'b0, 32'h23,   32'hFFFFFFFF, 1'b1, 32'h0,        1);
        add_vec(1'b1, R, 1'b0, 32'h20,   32'hFFFFFFFF, 1'b1, 32'h0,        1);
        add_vec(1'b1, B, 1'b0, 32'h2000, 32'h00000080, 1'b0, 32'h0,        2);
        add_vec(1'b0, B, 1'b0, 32'h0,    32'h0,        1'b0, 32'hFFFFFF80, 2);
        add_vec(1'b1, H, 1'b0, 32'h16,   32'h00008001, 1'b0, 32'h0,        2);
        add_vec(1'b0, H, 1'b0, 32'h16,   32'h0,        1'b0, 32'hFFFF8001, 2);
        add_vec(1'b0, H, 1'b1, 32'h16,   32'h0,        1'b0, 32'h00008001, 2);
        add_vec(1'b1, B, 1'b0, 32'h17,   32'hFFFFFFAB, 1'b0, 32'h0,        2);
        add_vec(1'b0, W, 1'b0, 32'h14,   32'h0,        1'b0, 32'hAB010000, 2);

        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            we0 = we_cnt;
            do_req(v);
            if (v.err) check($sformatf("err_no_write_%0d", i), 64'(we_cnt - we0), 64'd0);
            else if (v.we) check($sformatf("one_write_%0d", i), 64'(we_cnt - we0), 64'd1);
        end
        check("mem_err_target", 64'(mem[8]), 64'h0);
        check("mem_wrap_word0", 64'(mem[0]), 64'h00000080);

        // Back-to-back loads with req_valid held: accept every third cycle.
        wait_ready();
        req_valid = 1'b1; req_we = 1'b0; req_size = W; req_unsigned = 1'b0; req_addr = 32'h10;
        for (int k = 0; k < 3; k++) exp_q.push_back({4'd0, 1'b0, 32'h12340000});
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            check($sformatf("b2b_ready_%0d", k), 64'(req_ready), 64'((k % 3) == 2));
            if (k == 8) req_valid = 1'b0;
        end
        wait_drain();

        // Reset during the RD cycle of a sub-word store.
        v.we = 1'b1; v.size = W; v.uns = 1'b0; v.addr = 32'h40; v.wdata = 32'h11223344;
        v.err = 1'b0; v.rdata = 32'h0; v.lat = 1;
        do_req(v);
        wait_ready();
        we0 = we_cnt;
        req_valid = 1'b1; req_we = 1'b1; req_size = B; req_addr = 32'h41; req_wdata = 32'h55;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("rmw_ready_low", 64'(req_ready), 64'd0);
        #2 rst = 1'b1;
        #1;
        check("mid_reset_outputs",
              64'({req_ready, resp_valid, resp_err, resp_rdata, mem_we, mem_addr, mem_wdata}),
              64'({1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 11'h0, 32'h0}));
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(negedge clk); @(negedge clk);
        check("post_reset_ready", 64'(req_ready), 64'd1);
        check("post_reset_no_write", 64'(we_cnt - we0), 64'd0);
        check("post_reset_mem", 64'(mem[11'h10]), 64'h11223344);
        check("post_reset_queue", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
